// File: rtl/cam_lookup_ctrl.sv
// Clocked front-end for an 8-entry combinational CAM: registers the lookup key/mode,
// waits SETTLE cycles, then captures the CAM result into a held response. Optional statistics: CAM_LOOKUP_STATS_EN.
module cam_lookup_ctrl #(
    parameter int KEY_W  = 16,
    parameter int MODE_W = 2,
    parameter int ADDR_W = 3,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [KEY_W-1:0]  req_key,
    input  logic [MODE_W-1:0] req_mode,
    output logic [KEY_W-1:0]  cam_data_lookup,
    output logic [MODE_W-1:0] cam_init,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic              cam_valid,
    input  logic [ADDR_W-1:0] cam_num_match,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [ADDR_W-1:0] rsp_num_match,
    output logic              rsp_multi
`ifdef CAM_LOOKUP_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]  multi_count
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        capture;

    if (SETTLE < 1 || SETTLE > 15 || CNT_W < 1) begin : g_bad_param
        $error("cam_lookup_ctrl: SETTLE must be 1..15 and CNT_W >= 1");
    end

    // The CAM result is sampled on the last settle edge, i.e. SETTLE edges after accept.
    assign capture = (state_reg == WAIT) && (cnt_reg == 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            req_ready       <= 1'b1;
            rsp_valid       <= 1'b0;
            cam_data_lookup <= '0;
            cam_init        <= '0;
            rsp_hit         <= 1'b0;
            rsp_addr        <= '0;
            rsp_num_match   <= '0;
            rsp_multi       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        cam_data_lookup <= req_key;
                        cam_init        <= req_mode;
                        cnt_reg         <= 4'(SETTLE);
                        req_ready       <= 1'b0;
                        state_reg       <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (capture) begin
                        rsp_hit       <= cam_valid;
                        rsp_addr      <= cam_valid ? cam_addr : '0;
                        rsp_num_match <= cam_num_match;
                        rsp_multi     <= (cam_num_match > ADDR_W'(1));
                        rsp_valid     <= 1'b1;
                        state_reg     <= RESP;
                    end
                end
                RESP: begin
                    // Data fields are left as captured; only the handshake flag drops.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef CAM_LOOKUP_STATS_EN
    // Bit 0: hit, bit 1: miss, bit 2: multi-match.
    logic [2:0] stat_inc;
    assign stat_inc = {capture && (cam_num_match > ADDR_W'(1)),
                       capture && !cam_valid,
                       capture && cam_valid};

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (stats_clr) begin
                cnt_reg <= '0;
            end else if (stat_inc[gi] && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign hit_count   = g_stat[0].cnt_reg;
    assign miss_count  = g_stat[1].cnt_reg;
    assign multi_count = g_stat[2].cnt_reg;
`endif

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Self-checking bench for cam_lookup_ctrl: directed and random lookups against a
// behavioural CAM, plus a SETTLE=4 instance for latency and mid-operation reset.
module tb_cam_lookup_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Main instance, SETTLE=1
    logic        rst_n, req_valid, req_ready, rsp_valid, rsp_ready, rsp_hit, rsp_multi;
    logic [15:0] req_key, cam_data_lookup;
    logic [1:0]  req_mode, cam_init;
    logic [2:0]  cam_addr, cam_num_match, rsp_addr, rsp_num_match;
    logic        cam_valid;
    logic        stats_clr;
    logic [15:0] hit_count, miss_count, multi_count;

    // Second instance, SETTLE=4, fixed CAM result
    logic        rst4_n, d4_req_valid, d4_req_ready, d4_rsp_valid, d4_rsp_ready, d4_rsp_hit, d4_rsp_multi;
    logic [15:0] d4_req_key, d4_cam_data_lookup;
    logic [1:0]  d4_req_mode, d4_cam_init;
    logic [2:0]  d4_rsp_addr, d4_rsp_num_match;
    logic [15:0] d4_hit_count, d4_miss_count, d4_multi_count;

    logic [15:0] entries [8];

    cam_lookup_ctrl #(.SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_mode(req_mode),
        .cam_data_lookup(cam_data_lookup), .cam_init(cam_init),
        .cam_addr(cam_addr), .cam_valid(cam_valid), .cam_num_match(cam_num_match),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_addr(rsp_addr), .rsp_num_match(rsp_num_match), .rsp_multi(rsp_multi)
`ifdef CAM_LOOKUP_STATS_EN
        , .stats_clr(stats_clr), .hit_count(hit_count), .miss_count(miss_count), .multi_count(multi_count)
`endif
    );

    cam_lookup_ctrl #(.SETTLE(4)) dut4 (
        .clk(clk), .rst_n(rst4_n),
        .req_valid(d4_req_valid), .req_ready(d4_req_ready), .req_key(d4_req_key), .req_mode(d4_req_mode),
        .cam_data_lookup(d4_cam_data_lookup), .cam_init(d4_cam_init),
        .cam_addr(3'd5), .cam_valid(1'b1), .cam_num_match(3'd2),
        .rsp_valid(d4_rsp_valid), .rsp_ready(d4_rsp_ready), .rsp_hit(d4_rsp_hit),
        .rsp_addr(d4_rsp_addr), .rsp_num_match(d4_rsp_num_match), .rsp_multi(d4_rsp_multi)
`ifdef CAM_LOOKUP_STATS_EN
        , .stats_clr(1'b0), .hit_count(d4_hit_count), .miss_count(d4_miss_count), .multi_count(d4_multi_count)
`endif
    );

    // Behavioural CAM: lowest matching address wins, count of all matches.
    always_comb begin
        cam_valid     = 1'b0;
        cam_addr      = 3'd0;
        cam_num_match = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (entries[i] == cam_data_lookup) begin
                cam_valid     = 1'b1;
                cam_addr      = 3'(i);
                cam_num_match = cam_num_match + 3'd1;
            end
        end
    end

    int exp_hits = 0, exp_misses = 0, exp_multis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected response from the stored contents.
    function automatic void ref_lookup(input logic [15:0] key, output logic hit,
                                       output logic [2:0] addr, output logic [2:0] num,
                                       output logic multi);
        int n = 0;
        int first = -1;
        for (int i = 0; i < 8; i++) begin
            if (entries[i] == key) begin
                n++;
                if (first < 0) first = i;
            end
        end
        hit   = (n > 0);
        addr  = hit ? 3'(first) : 3'd0;
        num   = 3'(n);
        multi = (n > 1);
    endfunction

    // Called at posedge+1 with the DUT idle.
    task automatic lookup(input logic [15:0] key, input logic [1:0] mode, input int hold);
        logic e_hit, e_multi;
        logic [2:0] e_addr, e_num;
        ref_lookup(key, e_hit, e_addr, e_num, e_multi);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_key = key; req_mode = mode;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("cam_data_lookup", cam_data_lookup, key);
        check("cam_init", cam_init, mode);
        check("req_ready_wait", req_ready, 0);
        check("rsp_valid_wait", rsp_valid, 0);
        @(posedge clk); #1;
        check("rsp_valid_rise", rsp_valid, 1);
        check("rsp_hit", rsp_hit, e_hit);
        check("rsp_addr", rsp_addr, e_addr);
        check("rsp_num_match", rsp_num_match, e_num);
        check("rsp_multi", rsp_multi, e_multi);
        if (e_hit) exp_hits++; else exp_misses++;
        if (e_multi) exp_multis++;
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'($urandom); req_key = 16'($urandom); req_mode = 2'($urandom);
            @(posedge clk); #1;
            check("rsp_valid_held", rsp_valid, 1);
            check("req_ready_resp", req_ready, 0);
            check("cam_key_stable", cam_data_lookup, key);
            check("rsp_num_held", rsp_num_match, e_num);
        end
        // Request present on the handshake edge must not be accepted.
        rsp_ready = 1'b1; req_valid = 1'b1; req_key = key ^ 16'h5a5a;
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b0;
        check("rsp_valid_drop", rsp_valid, 0);
        check("req_ready_back", req_ready, 1);
        check("no_accept_on_hs", cam_data_lookup, key);
        check("rsp_hit_kept", rsp_hit, e_hit);
        check("rsp_addr_kept", rsp_addr, e_addr);
    endtask

    initial begin
        logic [15:0] dir_keys [10];
        dir_keys = '{16'd0, 16'd1, 16'd2, 16'd2, 16'd9, 16'd3, 16'd4, 16'd5, 16'd0, 16'd7};
        entries  = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 16'd0};
        rst_n = 1'b0; rst4_n = 1'b0; stats_clr = 1'b0;
        req_valid = 1'b0; req_key = '0; req_mode = '0; rsp_ready = 1'b0;
        d4_req_valid = 1'b0; d4_req_key = '0; d4_req_mode = '0; d4_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1; rst4_n = 1'b1;
        @(posedge clk); #1;

        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_cam_lookup", cam_data_lookup, 0);
        check("rst_cam_init", cam_init, 0);
        check("rst_rsp_fields", {rsp_hit, rsp_addr, rsp_num_match, rsp_multi}, 0);

        // Directed: hit on 2, miss on 9, triple match on 0 with backpressure.
        lookup(16'd2, 2'd3, 0);
        lookup(16'd9, 2'd3, 0);
        lookup(16'd0, 2'd1, 5);
        for (int i = 0; i < 10; i++) lookup(dir_keys[i], 2'(i), i % 3);
`ifdef CAM_LOOKUP_STATS_EN
        check("hit_count", hit_count, 32'(exp_hits));
        check("miss_count", miss_count, 32'(exp_misses));
        check("multi_count", multi_count, 32'(exp_multis));
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        check("clr_hit", hit_count, 0);
        check("clr_miss", miss_count, 0);
        check("clr_multi", multi_count, 0);
`endif
        exp_hits = 0; exp_misses = 0; exp_multis = 0;

        // Random contents and keys; entry 7 never matches so counts stay within 3 bits.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 7; i++) entries[i] = 16'($urandom_range(0, 5));
            entries[7] = 16'hffff;
            lookup(16'($urandom_range(0, 9)), 2'($urandom), int'($urandom_range(0, 4)));
        end
`ifdef CAM_LOOKUP_STATS_EN
        check("rand_hit_count", hit_count, 32'(exp_hits));
        check("rand_miss_count", miss_count, 32'(exp_misses));
        check("rand_multi_count", multi_count, 32'(exp_multis));
`endif

        // SETTLE=4: response appears exactly four edges after accept.
        d4_req_valid = 1'b1; d4_req_key = 16'hbeef; d4_req_mode = 2'd2;
        @(posedge clk); #1;
        d4_req_valid = 1'b0;
        check("d4_cam_lookup", d4_cam_data_lookup, 16'hbeef);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            check("d4_rsp_valid_early", d4_rsp_valid, 0);
        end
        @(posedge clk); #1;
        check("d4_rsp_valid", d4_rsp_valid, 1);
        check("d4_rsp_addr", d4_rsp_addr, 5);
        check("d4_rsp_num", d4_rsp_num_match, 2);
        check("d4_rsp_multi", d4_rsp_multi, 1);
        d4_rsp_ready = 1'b1;
        @(posedge clk); #1;
        d4_rsp_ready = 1'b0;
        check("d4_rsp_drop", d4_rsp_valid, 0);

        // Reset two cycles after accept: outputs clear without a clock edge.
        d4_req_valid = 1'b1; d4_req_key = 16'h1234; d4_req_mode = 2'd1;
        @(posedge clk); #1;
        d4_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst4_n = 1'b0;
        #1;
        check("d4_async_req_ready", d4_req_ready, 1);
        check("d4_async_rsp_valid", d4_rsp_valid, 0);
        check("d4_async_cam", {d4_cam_data_lookup, d4_cam_init}, 0);
        check("d4_async_rsp_fields", {d4_rsp_hit, d4_rsp_addr, d4_rsp_num_match, d4_rsp_multi}, 0);
        repeat (2) @(posedge clk);
        #1; rst4_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("d4_no_rsp_after_rst", d4_rsp_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_lookup_ctrl.md
Name: cam_lookup_ctrl

Overview:
- Sequential front-end controller that sits directly upstream of the 8-entry, 16-bit combinational CAM and also consumes its result.
- Accepts lookup requests over a valid/ready handshake and registers the key and mode onto the CAM's data_lookup/init inputs.
- Waits a programmable settle time, then captures the CAM's addr/valid/num_match into a held response with its own valid/ready handshake.
- Isolates the combinational CAM from the clocked request/response fabric.

Parameters:
KEY_W, 16, lookup key width; matches CAM data_lookup
MODE_W, 2, mode width; matches CAM init
ADDR_W, 3, CAM address / match-count width
SETTLE, 1, cycles the key is held on the CAM before capture; legal range 1..15
CNT_W, 16, statistics counter width (optional feature only)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_key  in  KEY_W  key to look up
req_mode  in  MODE_W  mode passed to CAM init
cam_data_lookup  out  KEY_W  registered key to CAM
cam_init  out  MODE_W  registered mode to CAM
cam_addr  in  ADDR_W  CAM matching address
cam_valid  in  1  CAM hit indication
cam_num_match  in  ADDR_W  CAM match count
rsp_valid  out  1  response held
rsp_ready  in  1  consumer accepts response
rsp_hit  out  1  captured cam_valid
rsp_addr  out  ADDR_W  captured cam_addr; 0 when rsp_hit=0
rsp_num_match  out  ADDR_W  captured cam_num_match
rsp_multi  out  1  captured cam_num_match > 1

Behaviour:
- Single clock domain. rst_n is asynchronous assert and synchronous release.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, cam_data_lookup=0, cam_init=0, rsp_hit=0, rsp_addr=0, rsp_num_match=0, rsp_multi=0, settle counter=0.
- FSM states: IDLE, WAIT, RESP.
- req_ready is high only in IDLE.
- IDLE: a rising edge with req_valid=1 is the accept edge E0.
  - Load cam_data_lookup<=req_key and cam_init<=req_mode.
  - Load counter<=SETTLE.
  - Go to WAIT.
- IDLE with req_valid=0: outputs hold; cam_data_lookup/cam_init keep their last value.
- WAIT: the counter decrements on each edge. On the edge where counter==1:
  - rsp_hit<=cam_valid
  - rsp_addr<=cam_valid ? cam_addr : 0
  - rsp_num_match<=cam_num_match
  - rsp_multi<=(cam_num_match>1)
  - rsp_valid<=1; go to RESP
- Latency: rsp_valid rises after edge E0+SETTLE. With SETTLE=1 it is high in the cycle immediately after the accept cycle.
- RESP: all rsp_* outputs and cam_* outputs stay stable while rsp_valid=1 and rsp_ready=0. There is no timeout.
- RESP with rsp_ready=1 at an edge: rsp_valid<=0; go to IDLE. The rsp_* data fields keep their last values.
- No back-to-back overlap. A request presented during a RESP handshake edge is not accepted because req_ready=0 then. The earliest next accept is the following edge.
- req_key/req_mode changes while not in IDLE are ignored.
- cam_num_match is captured unmodified, with no saturation or recount. rsp_multi is derived from it at capture.
- Reset mid-operation (WAIT or RESP): the in-flight request is dropped, no response is produced, and all outputs return to reset values immediately.

Optional Feature:
- Macro: CAM_LOOKUP_STATS_EN.
- Defined:
  - Adds outputs hit_count[CNT_W], miss_count[CNT_W], multi_count[CNT_W] and input stats_clr (1 bit, synchronous clear).
  - On each capture edge, increment hit_count if cam_valid else miss_count; also increment multi_count if cam_num_match>1.
  - Counters saturate at all-ones.
  - stats_clr wins over a simultaneous increment.
  - Counters reset to 0 on rst_n.
- Undefined: no ports, no logic; behaviour otherwise identical.

Test Plan:
1. Reset: rst_n=0, then release with req_valid=0 -> req_ready=1, rsp_valid=0, cam_data_lookup=0, cam_init=0, all rsp_* fields 0.
2. Single hit, SETTLE=1: CAM model stores 16'd2 at address 2. Send req_key=16'd2, req_mode=3 with rsp_ready=1.
   - cam_data_lookup=16'd2 and cam_init=3 after E0.
   - rsp_valid=1 after E0+1, with rsp_hit=1, rsp_addr=2, rsp_num_match=1, rsp_multi=0.
   - rsp_valid=0 one cycle later.
3. Miss: req_key=16'd9, mode 3 -> rsp_hit=0, rsp_addr=0, rsp_num_match=0.
4. Multi-match and backpressure: key 16'd0 with 3 matching entries, rsp_ready=0 for 5 cycles.
   - rsp_valid held, rsp_num_match=3, rsp_multi=1, req_ready=0 throughout.
   - A changing req_key is ignored.
   - rsp_ready=1 -> back to IDLE on the next edge.
5. Reset mid-WAIT with SETTLE=4: assert rst_n=0 two cycles after accept -> rsp_valid never rises and all outputs are at reset values asynchronously.
6. With CAM_LOOKUP_STATS_EN: 10 lookups matching the keys 0,1,2,2,9,3,4,5,0,7 against a CAM that hits on 0..5 -> hit_count=8, miss_count=2.
   - stats_clr pulse -> all counters 0 on the next edge.
